neopixel_ws2812_driver: RTL
===========================

// Module: neopixel_ws2812_driver
// PURPOSE
//  Avalon-MM slave behind the neopixel_0 conduit. It holds a small array of GRB pixel words and serialises
//  them onto the single WS2812 one-wire output, followed by the latch/reset low time.
//  The HPS writes the colours, sets the pixel count and triggers a frame. The frame-done IRQ tells software
//  when the chain has latched.
// PARAMETERS
//  MAX_PIXELS   16     pixel storage depth; NUM_PIXELS is clamped to this value
//  T0H_CYC      20     high time of a '0' bit, in clocks (0.4 us at 50 MHz)
//  T1H_CYC      40     high time of a '1' bit, in clocks (0.8 us)
//  TBIT_CYC     63     total bit period, in clocks (1.26 us); must be > T1H_CYC
//  TRESET_CYC   2750   latch low time after the last bit, in clocks (55 us)
//  REFRESH_CYC  2500000 auto-refresh period, in clocks (50 ms); used only with the macro
// PORTS
//  clock        in   1   system clock (50 MHz)
//  reset        in   1   asynchronous, active-high
//  address      in   8   word address
//  write        in   1   Avalon write strobe
//  writedata    in   32  write data
//  read         in   1   Avalon read strobe
//  readdata     out  32  read data, registered, valid 1 cycle after read
//  waitrequest  out  1   tied 0
//  irq          out  1   frame-done interrupt, level
//  one_wire     out  1   WS2812 data line
// BEHAVIOUR
//  Register map (word addresses):
//   0x00 CTRL  W: bit0 START, bit2 IRQ_CLR, bit3 IRQ_EN.
//              R: bit1 BUSY, bit2 IRQ_PEND, bit3 IRQ_EN.
//   0x01 NUM_PIXELS  R/W [7:0]; a write above MAX_PIXELS stores MAX_PIXELS.
//   0x10+i PIXEL[i]  R/W [23:0] = {G,R,B}, for i < MAX_PIXELS.
//   Unmapped reads return 0. Unmapped writes are ignored.
//  Reset values:
//   one_wire=0, irq=0, readdata=0, all pixels=0, NUM_PIXELS=0, IRQ_EN=0, FSM=IDLE.
//  FSM states: IDLE, LOAD, HIGH, LOW, LATCH.
//   IDLE->LOAD   on START with NUM_PIXELS != 0. A START while BUSY or with NUM_PIXELS == 0 is ignored.
//   LOAD   pix_idx=0; shift reg <= PIXEL[pix_idx]; bit_cnt=23; 1 cycle.
//   HIGH   one_wire=1 for T0H_CYC or T1H_CYC clocks, chosen by shift[23].
//   LOW    one_wire=0 until TBIT_CYC clocks in total for the bit. Then:
//            if bit_cnt != 0: shift left, bit_cnt--, go to HIGH;
//            else if pix_idx+1 < NUM_PIXELS: pix_idx++, go to LOAD;
//            else go to LATCH.
//   LATCH  one_wire=0 for TRESET_CYC clocks. Then IRQ_PEND=1 and go to IDLE.
//  Bit order: MSB first, G7..G0, R7..R0, B7..B0.
//  Bit period is exactly TBIT_CYC clocks, except a LOAD adds 1 clock to the low phase of the last bit of
//  the previous pixel. That is within WS2812 tolerance.
//  BUSY = (FSM != IDLE). one_wire is 0 in IDLE.
//  Pixel writes during BUSY are accepted. They affect pixels that have not been loaded yet; a pixel already
//  in the shift register is unaffected.
//  A NUM_PIXELS write during BUSY takes effect at the next frame. The count is latched at START.
//  irq = IRQ_PEND & IRQ_EN.
//  If IRQ_CLR and a frame completion happen in the same cycle, the completion wins (IRQ_PEND=1).
//  Asynchronous reset mid-frame: one_wire drops to 0 immediately, the FSM goes to IDLE, and pixels clear.
//  Counters are sized to $clog2 of the largest timing parameter. There is no wrap inside a frame.
// CONFIGURATION
//  NEOPIXEL_AUTO_REFRESH_EN defined:
//   - A free-running counter issues an internal START every REFRESH_CYC clocks when CTRL bit4 (AUTO) = 1.
//   - The internal START is dropped if BUSY. A host START in the same cycle merges into one frame.
//  NEOPIXEL_AUTO_REFRESH_EN undefined:
//   - No counter is built. CTRL bit4 reads 0 and writes to it are ignored.
// STRUCTURE
//  neopixel_pkg:
//   - state enum
//   - register offsets (CTRL, NUM_PIXELS, PIXEL_BASE)
//   - CTRL bit indices
//   - PIXEL_W = 24
//  Sub-module ws2812_bit_shifter:
//   - Owns the HIGH/LOW timing and the shift register.
//   - Handshake: load/pixel in, bit_done/pixel_done out.
//  The top level keeps the register file, the frame FSM, the IRQ logic and the optional refresh counter.
// TESTING
//  1. PIXEL[0]=0xFF0000, NUM=1, START:
//     - 8 pulses of 40 high / 23 low, then 16 pulses of 20 / 43.
//     - Then 2750 low clocks, then IRQ_PEND=1.
//  2. NUM=3 with pixels 0xA5A5A5, 0x000001, 0x800000:
//     - 72 bits decode correctly, MSB first.
//     - BUSY stays high until the latch ends; irq asserts only if IRQ_EN.
//  3. START while BUSY, and START with NUM=0: no extra frame, counters undisturbed.
//     NUM write of 40: reads back 16.
//  4. Assert reset at bit 10 of pixel 0:
//     - one_wire=0 in the same cycle; readdata of PIXEL[0]=0 after release.
//     - A fresh START works.
//  5. IRQ_CLR written in the completion cycle leaves IRQ_PEND=1. A later IRQ_CLR clears it.
//  6. Macro defined, AUTO=1, REFRESH_CYC=5000, NUM=1:
//     - Frames start every 5000 clocks.
//     - A host START coinciding with the tick yields one frame.

Source files
------------

// File: rtl/neopixel_pkg.sv
// Shared constants for the WS2812 driver: register map, CTRL bit positions,
// frame FSM state codes and a counter-width helper.
package neopixel_pkg;

  localparam int PIXEL_W = 24;

  localparam logic [7:0] REG_CTRL       = 8'h00;
  localparam logic [7:0] REG_NUM_PIXELS = 8'h01;
  localparam logic [7:0] REG_PIXEL_BASE = 8'h10;

  localparam int CTRL_START    = 0;
  localparam int CTRL_BUSY     = 1;
  localparam int CTRL_IRQ_CLR  = 2;
  localparam int CTRL_IRQ_PEND = 2;
  localparam int CTRL_IRQ_EN   = 3;
  localparam int CTRL_AUTO     = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_HIGH  = 3'd2;
  localparam logic [2:0] ST_LOW   = 3'd3;
  localparam logic [2:0] ST_LATCH = 3'd4;

  // Width able to count 0..max_val-1 (never narrower than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/ws2812_bit_shifter.sv
// Serialises one 24-bit GRB word MSB first with WS2812 high/low bit timing.
// load starts a word; high_done/bit_done/pixel_done report phase boundaries.
module ws2812_bit_shifter
  import neopixel_pkg::*;
#(
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int TBIT_CYC = 63,
  parameter int CNT_W    = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [PIXEL_W-1:0] pixel,
  output logic               one_wire,
  output logic               high_done,
  output logic               bit_done,
  output logic               pixel_done
);

  logic [PIXEL_W-1:0] shift_reg;
  logic [4:0]         bit_cnt_reg;
  logic [CNT_W-1:0]   cyc_cnt_reg;
  logic               active_reg;
  logic               high_reg;
  logic [CNT_W-1:0]   high_last;

  assign high_last  = shift_reg[PIXEL_W-1] ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  assign high_done  = active_reg && high_reg && (cyc_cnt_reg == high_last);
  assign bit_done   = active_reg && (cyc_cnt_reg == CNT_W'(TBIT_CYC - 1));
  assign pixel_done = bit_done && (bit_cnt_reg == 5'd0);
  assign one_wire   = high_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      cyc_cnt_reg <= '0;
      active_reg  <= 1'b0;
      high_reg    <= 1'b0;
    end else if (load) begin
      shift_reg   <= pixel;
      bit_cnt_reg <= 5'd23;
      cyc_cnt_reg <= '0;
      active_reg  <= 1'b1;
      high_reg    <= 1'b1;
    end else if (active_reg) begin
      if (bit_done) begin
        cyc_cnt_reg <= '0;
        if (bit_cnt_reg != 5'd0) begin
          shift_reg   <= shift_reg << 1;
          bit_cnt_reg <= bit_cnt_reg - 1'b1;
          high_reg    <= 1'b1;
        end else begin
          active_reg <= 1'b0;
          high_reg   <= 1'b0;
        end
      end else begin
        cyc_cnt_reg <= cyc_cnt_reg + 1'b1;
        if (high_done) high_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/neopixel_ws2812_driver.sv
// Avalon-MM WS2812 frame driver: register file, frame FSM, IRQ and latch timing.
// Optional auto-refresh timer is built only with NEOPIXEL_AUTO_REFRESH_EN defined.
module neopixel_ws2812_driver
  import neopixel_pkg::*;
#(
  parameter int MAX_PIXELS  = 16,
  parameter int T0H_CYC     = 20,
  parameter int T1H_CYC     = 40,
  parameter int TBIT_CYC    = 63,
  parameter int TRESET_CYC  = 2750,
  parameter int REFRESH_CYC = 2500000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq,
  output logic        one_wire
);

  localparam int CNT_W = cnt_width((TRESET_CYC > TBIT_CYC) ? TRESET_CYC : TBIT_CYC);
  localparam int IDX_W = cnt_width(MAX_PIXELS);

  logic [PIXEL_W-1:0] pix_mem [MAX_PIXELS];
  logic [MAX_PIXELS-1:0] pix_wr_sel;
  logic [7:0]         pix_off;
  logic               pix_hit;
  logic [7:0]         num_reg;
  logic [7:0]         num_lat_reg;
  logic [IDX_W-1:0]   pix_idx_reg;
  logic [2:0]         state_reg;
  logic [CNT_W-1:0]   latch_cnt_reg;
  logic               irq_en_reg;
  logic               irq_pend_reg;
  logic               ctrl_wr;
  logic               start_req;
  logic               refresh_tick;
  logic               busy;
  logic               frame_done;
  logic               high_done;
  logic               bit_done;
  logic               pixel_done;
  logic [31:0]        rd_mux;
  logic               unused_bits;

  assign waitrequest = 1'b0;
  assign unused_bits = ^writedata[31:PIXEL_W];

  assign ctrl_wr    = write && (address == REG_CTRL);
  assign start_req  = (ctrl_wr && writedata[CTRL_START]) || refresh_tick;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = (state_reg == ST_LATCH) && (latch_cnt_reg == CNT_W'(TRESET_CYC - 1));
  assign irq        = irq_pend_reg & irq_en_reg;

  assign pix_off = address - REG_PIXEL_BASE;
  assign pix_hit = (address >= REG_PIXEL_BASE) && (pix_off < 8'(MAX_PIXELS));

  genvar gi;
  generate
    for (gi = 0; gi < MAX_PIXELS; gi++) begin : g_pix_sel
      assign pix_wr_sel[gi] = write && pix_hit && (pix_off == 8'(gi));
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_PIXELS; i++) pix_mem[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_PIXELS; i++)
        if (pix_wr_sel[i]) pix_mem[i] <= writedata[PIXEL_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_reg      <= '0;
      irq_en_reg   <= 1'b0;
      irq_pend_reg <= 1'b0;
    end else begin
      if (write && (address == REG_NUM_PIXELS))
        num_reg <= (writedata[7:0] > 8'(MAX_PIXELS)) ? 8'(MAX_PIXELS) : writedata[7:0];
      if (ctrl_wr) irq_en_reg <= writedata[CTRL_IRQ_EN];
      // A completion in the same cycle as IRQ_CLR must not be lost.
      if (frame_done) irq_pend_reg <= 1'b1;
      else if (ctrl_wr && writedata[CTRL_IRQ_CLR]) irq_pend_reg <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      pix_idx_reg   <= '0;
      num_lat_reg   <= '0;
      latch_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_req && (num_reg != 8'd0)) begin
            state_reg   <= ST_LOAD;
            pix_idx_reg <= '0;
            num_lat_reg <= num_reg;
          end
        end
        ST_LOAD: state_reg <= ST_HIGH;
        ST_HIGH: if (high_done) state_reg <= ST_LOW;
        ST_LOW: begin
          if (pixel_done) begin
            if ((8'(pix_idx_reg) + 8'd1) < num_lat_reg) begin
              pix_idx_reg <= pix_idx_reg + 1'b1;
              state_reg   <= ST_LOAD;
            end else begin
              latch_cnt_reg <= '0;
              state_reg     <= ST_LATCH;
            end
          end else if (bit_done) begin
            state_reg <= ST_HIGH;
          end
        end
        ST_LATCH: begin
          if (frame_done) state_reg <= ST_IDLE;
          else latch_cnt_reg <= latch_cnt_reg + 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  ws2812_bit_shifter #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC),
    .CNT_W    (CNT_W)
  ) u_shifter (
    .clock      (clock),
    .reset      (reset),
    .load       (state_reg == ST_LOAD),
    .pixel      (pix_mem[pix_idx_reg]),
    .one_wire   (one_wire),
    .high_done  (high_done),
    .bit_done   (bit_done),
    .pixel_done (pixel_done)
  );

`ifdef NEOPIXEL_AUTO_REFRESH_EN
  localparam int REF_W = cnt_width(REFRESH_CYC);
  logic [REF_W-1:0] refresh_cnt_reg;
  logic             auto_reg;

  // Free-running; a tick while busy is simply not acted on by the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      refresh_cnt_reg <= '0;
      auto_reg        <= 1'b0;
    end else begin
      if (ctrl_wr) auto_reg <= writedata[CTRL_AUTO];
      if (refresh_cnt_reg == REF_W'(REFRESH_CYC - 1)) refresh_cnt_reg <= '0;
      else refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
    end
  end

  assign refresh_tick = auto_reg && (refresh_cnt_reg == REF_W'(REFRESH_CYC - 1));
`else
  assign refresh_tick = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    if (address == REG_CTRL) begin
      rd_mux[CTRL_BUSY]     = busy;
      rd_mux[CTRL_IRQ_PEND] = irq_pend_reg;
      rd_mux[CTRL_IRQ_EN]   = irq_en_reg;
`ifdef NEOPIXEL_AUTO_REFRESH_EN
      rd_mux[CTRL_AUTO]     = auto_reg;
`endif
    end else if (address == REG_NUM_PIXELS) begin
      rd_mux[7:0] = num_reg;
    end else if (pix_hit) begin
      rd_mux[PIXEL_W-1:0] = pix_mem[pix_off[IDX_W-1:0]];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) readdata <= '0;
    else if (read) readdata <= rd_mux;
  end

endmodule
